// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from a show-ahead FIFO and shifts them out LSB first.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high; pops the FIFO head when it is not empty
// S_START  | start bit (tx low) for one bit period
// S_DATA   | DATA_WIDTH data bits, LSB first
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | line high for one or two bit periods
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  stop2_i,
`ifdef UART_TX_PARITY_EN
  input  logic                  parity_odd_i,
`endif
  input  logic [DATA_WIDTH-1:0] dfifo_data_i,
  input  logic                  dfifo_empty_i,
  output logic                  dfifo_rd_o,
  output logic                  tx_o,
  output logic                  tx_busy_o,
  output logic                  tx_done_o
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic [DIV_WIDTH-1:0]  r_baud_cnt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_stop_left;
  logic                  w_bit_end;
  logic                  w_pop;
  logic                  w_done;
`ifdef UART_TX_PARITY_EN
  logic                  r_par_bit;
`endif

  // Gating with rstn_i keeps the pop strobe low while reset is held.
  assign w_pop       = (r_state == S_IDLE) && !dfifo_empty_i && rstn_i;
  assign w_bit_end   = (r_baud_cnt == '0);
  assign w_shift_nxt = r_shift >> 1;
  assign w_done      = (r_state == S_STOP) && w_bit_end && !r_stop_left;

  assign dfifo_rd_o  = w_pop;
  assign tx_o        = r_tx;
  assign tx_busy_o   = (r_state != S_IDLE) || w_pop;
  assign tx_done_o   = w_done;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_pop) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == '0) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par_bit;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_tx_nxt = w_shift_nxt[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Frame settings are captured only at the pop edge so mid-frame changes wait for the next word.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_baud_cnt  <= '0;
      r_div       <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_stop_left <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_bit   <= 1'b0;
`endif
    end else if (w_pop) begin
      r_baud_cnt  <= baud_div_i;
      r_div       <= baud_div_i;
      r_shift     <= dfifo_data_i;
      r_bit_cnt   <= BW'(DATA_WIDTH - 1);
      r_stop_left <= stop2_i;
`ifdef UART_TX_PARITY_EN
      r_par_bit   <= (^dfifo_data_i) ^ parity_odd_i;
`endif
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        r_baud_cnt <= r_div;
      end else begin
        r_baud_cnt <= r_baud_cnt - 1'b1;
      end
      if ((r_state == S_DATA) && w_bit_end && (r_bit_cnt != '0)) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if ((r_state == S_STOP) && w_bit_end) begin
        r_stop_left <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a queue-based show-ahead FIFO model.
// Parity frames are checked when UART_TX_PARITY_EN is defined.
module tb_uart_tx_serializer;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [15:0] baud_div_i;
  logic        stop2_i;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd_i;
`endif
  logic [7:0]  dfifo_data_i;
  logic        dfifo_empty_i;
  logic        dfifo_rd_o;
  logic        tx_o;
  logic        tx_busy_o;
  logic        tx_done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  logic s_tx, s_rd, s_busy, s_done;
  logic [7:0] q[$];

  always #5 clk_i = ~clk_i;

  uart_tx_serializer #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .baud_div_i   (baud_div_i),
    .stop2_i      (stop2_i),
`ifdef UART_TX_PARITY_EN
    .parity_odd_i (parity_odd_i),
`endif
    .dfifo_data_i (dfifo_data_i),
    .dfifo_empty_i(dfifo_empty_i),
    .dfifo_rd_o   (dfifo_rd_o),
    .tx_o         (tx_o),
    .tx_busy_o    (tx_busy_o),
    .tx_done_o    (tx_done_o)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    dfifo_empty_i = (q.size() == 0);
    dfifo_data_i  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: sample outputs at the falling edge, apply FIFO pops just after the rising edge.
  task automatic cyc();
    @(negedge clk_i);
    s_tx   = tx_o;
    s_rd   = dfifo_rd_o;
    s_busy = tx_busy_o;
    s_done = tx_done_o;
    if (s_rd) n_pops++;
    @(posedge clk_i);
    #1;
    if (s_rd && q.size() != 0) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic expect_frame(input logic [7:0] data, input int div, input logic st2,
                              input int wait_max, input int chg_at, input logic [15:0] chg_val,
                              input string tag);
    logic got;
    logic bits[$];
    int   fc, ndone, done_at, bad;
    got = 1'b0;
    for (int i = 0; i < wait_max; i++) begin
      cyc();
      if (s_rd) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_pop"}, got, 1);
    if (!got) return;
    check({tag, "_busy_pop"}, s_busy, 1);
    check({tag, "_idle_tx"}, s_tx, 1);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^data) ^ parity_odd_i);
`endif
    bits.push_back(1'b1);
    if (st2) bits.push_back(1'b1);
    fc = 0; ndone = 0; done_at = 0;
    for (int b = 0; b < bits.size(); b++) begin
      bad = 0;
      for (int k = 0; k <= div; k++) begin
        if (fc == chg_at) baud_div_i = chg_val;
        cyc();
        fc++;
        if (s_tx !== bits[b] || s_busy !== 1'b1 || s_rd !== 1'b0) bad++;
        if (s_done) begin
          ndone++;
          done_at = fc;
        end
      end
      check($sformatf("%s_bit%0d", tag, b), bad, 0);
    end
    check({tag, "_done_at"}, done_at, bits.size() * (div + 1));
    check({tag, "_done_cnt"}, ndone, 1);
  endtask

  initial begin
    int bad;
    logic got;
    rstn_i     = 1'b0;
    baud_div_i = 16'd3;
    stop2_i    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_odd_i = 1'b0;
`endif
    q.push_back(8'hA5);
    drive_fifo();
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_tx", tx_o, 1);
    check("rst_rd", dfifo_rd_o, 0);
    check("rst_busy", tx_busy_o, 0);
    check("rst_done", tx_done_o, 0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // 0xA5, 4-clock bits, one stop bit: done on frame clock 40
    expect_frame(8'hA5, 3, 1'b0, 3, -1, 16'd0, "basic");
    check("basic_pops", n_pops, 1);

    bad = 0;
    repeat (100) begin
      cyc();
      if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_rd !== 1'b0) bad++;
    end
    check("empty_idle", bad, 0);

    baud_div_i = 16'd1;
    q.push_back(8'hA5);
    drive_fifo();
    expect_frame(8'hA5, 1, 1'b0, 3, -1, 16'd0, "par_even");
`ifdef UART_TX_PARITY_EN
    parity_odd_i = 1'b1;
`endif
    q.push_back(8'hA5);
    drive_fifo();
    expect_frame(8'hA5, 1, 1'b0, 3, -1, 16'd0, "par_odd");
`ifdef UART_TX_PARITY_EN
    parity_odd_i = 1'b0;
`endif

    // back-to-back: second pop must be the first clock after the previous frame
    baud_div_i = 16'd0;
    stop2_i    = 1'b1;
    q.push_back(8'h00);
    q.push_back(8'hFF);
    drive_fifo();
    expect_frame(8'h00, 0, 1'b1, 3, -1, 16'd0, "b2b0");
    expect_frame(8'hFF, 0, 1'b1, 1, -1, 16'd0, "b2b1");
    check("b2b_pops", n_pops, 5);

    baud_div_i = 16'd3;
    stop2_i    = 1'b0;
    q.push_back(8'h3C);
    q.push_back(8'hC3);
    drive_fifo();
    expect_frame(8'h3C, 3, 1'b0, 3, 10, 16'd7, "divchg0");
    expect_frame(8'hC3, 7, 1'b0, 1, -1, 16'd0, "divchg1");

    // reset during data bit 3 of 0x52 (bit 3 is low)
    baud_div_i = 16'd3;
    q.push_back(8'h52);
    drive_fifo();
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (s_rd) begin
        got = 1'b1;
        break;
      end
    end
    check("rstmid_pop", got, 1);
    repeat (18) cyc();
    check("rstmid_pre_tx", s_tx, 0);
    #2;
    rstn_i = 1'b0;
    #1;
    check("rstmid_tx", tx_o, 1);
    check("rstmid_busy", tx_busy_o, 0);
    check("rstmid_done", tx_done_o, 0);
    bad = 0;
    repeat (3) begin
      cyc();
      if (s_done !== 1'b0 || s_busy !== 1'b0 || s_tx !== 1'b1) bad++;
    end
    check("rstmid_hold", bad, 0);
    rstn_i = 1'b1;
    q.push_back(8'h96);
    drive_fifo();
    expect_frame(8'h96, 3, 1'b0, 3, -1, 16'd0, "post_rst");

    check("total_pops", n_pops, 9);
    check("fifo_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, matching the downstream FIFO word width.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor input.
REQ-003 SHALL have port clk_i, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port baud_div_i, input, DIV_WIDTH: bit period minus one, in clk_i cycles.
REQ-006 SHALL have port stop2_i, input, 1: 0 selects one stop bit, 1 selects two.
REQ-007 SHALL have port dfifo_data_i, input, DATA_WIDTH: show-ahead head word of the downstream FIFO.
REQ-008 SHALL have port dfifo_empty_i, input, 1: downstream FIFO empty flag.
REQ-009 SHALL have port dfifo_rd_o, output, 1: one-cycle pop strobe to the downstream FIFO.
REQ-010 SHALL have port tx_o, output, 1: serial line; idle level high.
REQ-011 SHALL have port tx_busy_o, output, 1: frame in progress; feeds the STATS tx_status bit.
REQ-012 SHALL have port tx_done_o, output, 1: one-cycle pulse at frame end; feeds the tx_done IRQ event.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY and STOP.
REQ-014 SHALL, in IDLE with dfifo_empty_i=0, assert dfifo_rd_o for exactly one cycle and latch dfifo_data_i, baud_div_i and stop2_i on that same edge; the next state is START.
REQ-015 SHALL NOT sample baud_div_i, stop2_i or the parity mode mid-frame; changes take effect from the next pop.
REQ-016 SHALL hold each bit on tx_o for exactly baud_div+1 clocks using a down-counter reloaded at every bit boundary.
REQ-017 SHALL treat baud_div=0 as a legal 1-clock bit period.
REQ-018 SHALL drive tx_o=0 in START, then send the DATA_WIDTH data bits LSB first using a bit counter.
REQ-019 SHALL go from DATA to PARITY when the parity feature is compiled in, otherwise to STOP.
REQ-020 SHALL drive tx_o=1 in STOP for one bit period, or two when the latched stop2=1.
REQ-021 SHALL assert tx_done_o on the last clock of STOP and return to IDLE on the following edge.
REQ-022 SHALL register tx_o, with no combinational path from any input to tx_o.
REQ-023 SHALL assert tx_busy_o in every state except IDLE, and also during the pop cycle.
REQ-024 SHALL stay in IDLE with dfifo_rd_o=0 and tx_o=1 while dfifo_empty_i=1, and never pop an empty FIFO.
REQ-025 SHALL, for back-to-back words, spend exactly one IDLE/pop cycle between the end of STOP and the next START.

Reset
REQ-026 SHALL, on rstn_i low, asynchronously force: state=IDLE, tx_o=1, dfifo_rd_o=0, tx_busy_o=0, tx_done_o=0, and clear all counters and latched data.
REQ-027 SHALL abandon a frame interrupted by reset mid-operation, with no tx_done_o; the popped word is lost.

Configuration
REQ-028 SHALL have macro UART_TX_PARITY_EN; when defined, add input parity_odd_i (1 bit: 0=even, 1=odd), latched at pop, and insert a PARITY state of one bit period carrying the XOR of the data bits, inverted for odd.
REQ-029 SHALL, when UART_TX_PARITY_EN is undefined, have no parity_odd_i port, no PARITY state and no parity logic.

Verification
REQ-030 SHALL cover basic frame: baud_div=3, stop2=0, no parity, FIFO holds 0xA5 -> dfifo_rd_o 1 cycle; tx_o = 0 for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks; tx_done_o pulses on frame clock 40.
REQ-031 SHALL cover parity: UART_TX_PARITY_EN defined, baud_div=1, 0xA5 -> parity bit 0 with parity_odd_i=0 and 1 with parity_odd_i=1; frame is 22 clocks.
REQ-032 SHALL cover back-to-back: words 0x00 and 0xFF queued, baud_div=0, stop2=1 -> exactly 1 idle clock between frames; each frame 11 clocks; two tx_done_o pulses and two pops.
REQ-033 SHALL cover empty FIFO: dfifo_empty_i=1 for 100 clocks -> tx_o=1, tx_busy_o=0, dfifo_rd_o never asserted.
REQ-034 SHALL cover reset mid-frame: rstn_i low during DATA bit 3 -> tx_o=1 immediately without waiting for a clock, no tx_done_o; after release, the next word transmits normally.
REQ-035 SHALL cover divisor change: baud_div changed 3->7 mid-frame -> current frame keeps 4-clock bits; next frame uses 8-clock bits.
